// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: window base and register offsets.
// Offsets are byte addresses within the 256-byte window; decode uses addr[7:2].
package mmio_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'hFFFF_FF00;
    localparam int          NUM_BUTTONS       = 3;
    localparam int          NUM_SWITCHES      = 10;

    typedef enum logic [5:0] {
        IDX_LEDS = 6'd0,
        IDX_SEG  = 6'd1,
        IDX_SW   = 6'd2,
        IDX_BTN  = 6'd3,
        IDX_EVT  = 6'd4,
        IDX_CYC  = 6'd5
    } reg_idx_e;

    localparam logic [7:0] OFF_LEDS = {IDX_LEDS, 2'b00};
    localparam logic [7:0] OFF_SEG  = {IDX_SEG,  2'b00};
    localparam logic [7:0] OFF_SW   = {IDX_SW,   2'b00};
    localparam logic [7:0] OFF_BTN  = {IDX_BTN,  2'b00};
    localparam logic [7:0] OFF_EVT  = {IDX_EVT,  2'b00};
    localparam logic [7:0] OFF_CYC  = {IDX_CYC,  2'b00};

endpackage

// File: rtl/button_debounce.sv
// One push button: 2-flop synchroniser, stability counter, accepted level and
// a rise strobe that is high on the cycle the accepted level goes 0->1.
module button_debounce
    import mmio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;
    logic             settled;

    // The counter has already seen DEBOUNCE_CYCLES-1 differing samples, so this
    // edge is the DEBOUNCE_CYCLES-th one and the new level is accepted.
    assign settled = (sync_q != level) && (cnt == CNT_MAX);
    assign rise    = settled && sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
            if (sync_q == level) begin
                cnt <= '0;
            end else if (settled) begin
                level <= sync_q;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_io_responder.sv
// Memory-mapped board I/O on the CPU data bus: LED/7-seg registers, switches,
// debounced buttons with sticky W1C press events, and a free-running cycle counter.
module mmio_io_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = BASE_ADDR_DEFAULT,
    parameter int          DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        rsel,
    input  logic [2:0]  buttons_n,
    input  logic [9:0]  switchs,
    output logic [9:0]  leds,
    output logic [7:0]  seg
);

    logic [5:0]  word_idx;
    logic        wr_en;
    logic [9:0]  sw_meta;
    logic [9:0]  sw_sync;
    logic [2:0]  btn_level;
    logic [2:0]  btn_rise;
    logic [2:0]  evt;
    logic [2:0]  evt_clr;
    logic [31:0] cyc;
    logic [31:0] read_mux;
    logic        unused_bits;

    assign word_idx    = addr[7:2];
    assign sel         = (addr[31:8] == BASE_ADDR[31:8]);
    assign wr_en       = sel && we;
    assign evt_clr     = (wr_en && (word_idx == IDX_EVT)) ? wdata[2:0] : 3'b000;
    assign unused_bits = ^{addr[1:0], wdata[31:10]};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (~buttons_n[i]),
            .level(btn_level[i]),
            .rise (btn_rise[i])
        );
    end

    always_comb begin
        read_mux = 32'd0;
        case (word_idx)
            IDX_LEDS: read_mux = {22'd0, leds};
            IDX_SEG:  read_mux = {24'd0, seg};
            IDX_SW:   read_mux = {22'd0, sw_sync};
            IDX_BTN:  read_mux = {29'd0, btn_level};
            IDX_EVT:  read_mux = {29'd0, evt};
            IDX_CYC:  read_mux = cyc;
            default:  read_mux = 32'd0;
        endcase
    end

    // rdata captures pre-write state, so a read-during-write returns the old
    // value; a press rise overrides a W1C clear landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds    <= 10'd0;
            seg     <= 8'hFF;
            evt     <= 3'b000;
            cyc     <= 32'd0;
            rdata   <= 32'd0;
            rsel    <= 1'b0;
            sw_meta <= 10'd0;
            sw_sync <= 10'd0;
        end else begin
            if (wr_en && (word_idx == IDX_LEDS)) begin
                leds <= wdata[9:0];
            end
            if (wr_en && (word_idx == IDX_SEG)) begin
                seg <= wdata[7:0];
            end
            evt     <= (evt & ~evt_clr) | btn_rise;
            cyc     <= cyc + 32'd1;
            rdata   <= sel ? read_mux : 32'd0;
            rsel    <= sel;
            sw_meta <= switchs;
            sw_sync <= sw_meta;
        end
    end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Self-checking bench for mmio_io_responder: directed table, hand-written button
// sequences and randomized traffic, all compared against a behavioural model.
module tb_mmio_io_responder;
    import mmio_pkg::*;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        sel;
    logic [31:0] rdata;
    logic        rsel;
    logic [2:0]  buttons_n;
    logic [9:0]  switchs;
    logic [9:0]  leds;
    logic [7:0]  seg;

    int vectors     = 0;
    int miscompares = 0;

    mmio_io_responder #(
        .BASE_ADDR      (32'hFFFF_FF00),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .sel      (sel),
        .rdata    (rdata),
        .rsel     (rsel),
        .buttons_n(buttons_n),
        .switchs  (switchs),
        .leds     (leds),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    // Model: registers as plain values, switches/buttons delayed two samples,
    // a button's level flips once its last DEB synchronised samples all disagree.
    logic [9:0]     m_leds;
    logic [7:0]     m_seg;
    logic [2:0]     m_evt;
    logic [2:0]     m_stable;
    logic [31:0]    m_cyc;
    logic [31:0]    m_rdata;
    logic           m_rsel;
    logic [9:0]     m_sw_d1, m_sw_d2;
    logic [2:0]     m_btn_d1, m_btn_d2;
    logic [DEB-1:0] m_hist [3];

    function automatic logic [31:0] model_reg(input logic [5:0] idx);
        case (idx)
            6'd0:    return {22'd0, m_leds};
            6'd1:    return {24'd0, m_seg};
            6'd2:    return {22'd0, m_sw_d2};
            6'd3:    return {29'd0, m_stable};
            6'd4:    return {29'd0, m_evt};
            6'd5:    return m_cyc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelStep();
        logic       s;
        logic [2:0] clr;
        logic [2:0] rise;
        if (rst) begin
            m_leds = 10'd0; m_seg = 8'hFF; m_evt = 3'b0; m_stable = 3'b0;
            m_cyc = 32'd0; m_rdata = 32'd0; m_rsel = 1'b0;
            m_sw_d1 = 10'd0; m_sw_d2 = 10'd0; m_btn_d1 = 3'b0; m_btn_d2 = 3'b0;
            for (int b = 0; b < 3; b++) m_hist[b] = '0;
        end else begin
            m_rsel  = (addr[31:8] == 24'hFF_FFFF);
            m_rdata = m_rsel ? model_reg(addr[7:2]) : 32'd0;
            clr = 3'b0;
            if (m_rsel && we) begin
                case (addr[7:2])
                    6'd0:    m_leds = wdata[9:0];
                    6'd1:    m_seg  = wdata[7:0];
                    6'd4:    clr    = wdata[2:0];
                    default: ;
                endcase
            end
            rise = 3'b0;
            for (int b = 0; b < 3; b++) begin
                s           = m_btn_d2[b];
                m_btn_d2[b] = m_btn_d1[b];
                m_btn_d1[b] = ~buttons_n[b];
                m_hist[b]   = {m_hist[b][DEB-2:0], s};
                if (m_hist[b] == {DEB{~m_stable[b]}}) begin
                    m_stable[b] = ~m_stable[b];
                    rise[b]     = m_stable[b];
                end
            end
            m_evt   = (m_evt & ~clr) | rise;
            m_sw_d2 = m_sw_d1;
            m_sw_d1 = switchs;
            m_cyc   = m_cyc + 32'd1;
        end
    endtask

    task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic checkOutput();
        checkField("sel",   {31'd0, sel},  {31'd0, (addr[31:8] == 24'hFF_FFFF)});
        checkField("rdata", rdata,         m_rdata);
        checkField("rsel",  {31'd0, rsel}, {31'd0, m_rsel});
        checkField("leds",  {22'd0, leds}, {22'd0, m_leds});
        checkField("seg",   {24'd0, seg},  {24'd0, m_seg});
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic [31:0] wd, input logic w);
        rst   = r;
        addr  = a;
        wdata = wd;
        we    = w;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleRead(input logic [7:0] off);
        applyStimulus(1'b0, {24'hFF_FFFF, off}, 32'd0, 1'b0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] exp_rdata;
        logic        exp_rsel;
        logic [9:0]  exp_leds;
        logic [7:0]  exp_seg;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{32'hFFFF_FF00, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 10'h000, 8'hFF};
        tbl[1]  = '{32'hFFFF_FF04, 32'h0000_0000, 1'b0, 32'h0000_00FF, 1'b1, 10'h000, 8'hFF};
        tbl[2]  = '{32'hFFFF_FF08, 32'h0000_0000, 1'b0, 32'h0000_02C5, 1'b1, 10'h000, 8'hFF};
        tbl[3]  = '{32'hFFFF_FF0C, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 10'h000, 8'hFF};
        tbl[4]  = '{32'hFFFF_FF10, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 10'h000, 8'hFF};
        tbl[5]  = '{32'hFFFF_FF00, 32'hFFFF_F3A5, 1'b1, 32'h0000_0000, 1'b1, 10'h3A5, 8'hFF};
        tbl[6]  = '{32'hFFFF_FF00, 32'h0000_0000, 1'b0, 32'h0000_03A5, 1'b1, 10'h3A5, 8'hFF};
        tbl[7]  = '{32'hFFFF_FF08, 32'h0000_0000, 1'b1, 32'h0000_02C5, 1'b1, 10'h3A5, 8'hFF};
        tbl[8]  = '{32'hFFFF_FF08, 32'h0000_0000, 1'b0, 32'h0000_02C5, 1'b1, 10'h3A5, 8'hFF};
        tbl[9]  = '{32'hFFFF_FF04, 32'h1234_5600, 1'b1, 32'h0000_00FF, 1'b1, 10'h3A5, 8'h00};
        tbl[10] = '{32'hFFFF_FF04, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 10'h3A5, 8'h00};
        tbl[11] = '{32'h0000_0040, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 10'h3A5, 8'h00};
        tbl[12] = '{32'hFFFF_FF3C, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 10'h3A5, 8'h00};
        tbl[13] = '{32'hFFFF_FF14, 32'h0000_0000, 1'b0, 32'h0000_000D, 1'b1, 10'h3A5, 8'h00};
        tbl[14] = '{32'hFFFF_FF14, 32'hFFFF_FFFF, 1'b1, 32'h0000_000E, 1'b1, 10'h3A5, 8'h00};
        tbl[15] = '{32'hFFFF_FF03, 32'h0000_0000, 1'b0, 32'h0000_03A5, 1'b1, 10'h3A5, 8'h00};
        tbl[16] = '{32'hFFFF_FF10, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 10'h3A5, 8'h00};

        buttons_n = 3'b111;
        switchs   = 10'h2C5;
        applyStimulus(1'b1, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 32'd0, 32'd0, 1'b0);
        checkField("reset_leds",  {22'd0, leds}, 32'd0);
        checkField("reset_seg",   {24'd0, seg},  32'hFF);
        checkField("reset_rdata", rdata,         32'd0);
        checkField("reset_rsel",  {31'd0, rsel}, 32'd0);

        // Register map walk; CYC rows count cycles since reset release.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, tbl[i].addr, tbl[i].wdata, tbl[i].we);
            checkField($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
            checkField($sformatf("tbl%0d_rsel", i), {31'd0, rsel}, {31'd0, tbl[i].exp_rsel});
            checkField($sformatf("tbl%0d_leds", i), {22'd0, leds}, {22'd0, tbl[i].exp_leds});
            checkField($sformatf("tbl%0d_seg", i), {24'd0, seg}, {24'd0, tbl[i].exp_seg});
        end

        // A 3-cycle glitch on button 1 must be rejected.
        buttons_n = 3'b101;
        for (int k = 0; k < 3; k++) idleRead(OFF_BTN);
        buttons_n = 3'b111;
        for (int k = 0; k < 6; k++) begin
            idleRead(OFF_BTN);
            checkField("glitch_btn", rdata, 32'd0);
        end
        idleRead(OFF_EVT);
        checkField("glitch_evt", rdata, 32'd0);

        // Held press: level accepted on the 6th edge, visible in rdata one edge later.
        buttons_n = 3'b101;
        for (int k = 1; k <= 9; k++) begin
            idleRead(OFF_BTN);
            checkField($sformatf("press_btn_k%0d", k), rdata, (k >= 7) ? 32'd2 : 32'd0);
        end
        idleRead(OFF_EVT);
        checkField("press_evt", rdata, 32'd2);

        // W1C clear of bit 0 only.
        buttons_n = 3'b100;
        for (int k = 0; k < 8; k++) idleRead(OFF_LEDS);
        idleRead(OFF_EVT);
        checkField("evt_both", rdata, 32'd3);
        applyStimulus(1'b0, {24'hFF_FFFF, OFF_EVT}, 32'd1, 1'b1);
        checkField("evt_w1c_old", rdata, 32'd3);
        idleRead(OFF_EVT);
        checkField("evt_w1c", rdata, 32'd2);

        // Release, clear, then collide a clear with a fresh rise on button 1.
        buttons_n = 3'b111;
        for (int k = 0; k < 8; k++) idleRead(OFF_LEDS);
        applyStimulus(1'b0, {24'hFF_FFFF, OFF_EVT}, 32'd2, 1'b1);
        idleRead(OFF_EVT);
        checkField("evt_cleared", rdata, 32'd0);
        buttons_n = 3'b101;
        for (int k = 0; k < 5; k++) idleRead(OFF_LEDS);
        applyStimulus(1'b0, {24'hFF_FFFF, OFF_EVT}, 32'd2, 1'b1);
        idleRead(OFF_EVT);
        checkField("evt_set_wins", rdata, 32'd2);

        // Reset mid-debounce on button 2 with LEDs lit.
        buttons_n = 3'b111;
        for (int k = 0; k < 8; k++) idleRead(OFF_LEDS);
        buttons_n = 3'b011;
        for (int k = 0; k < 4; k++) idleRead(OFF_BTN);
        applyStimulus(1'b1, {24'hFF_FFFF, OFF_BTN}, 32'd0, 1'b0);
        checkField("rst2_leds",  {22'd0, leds}, 32'd0);
        checkField("rst2_seg",   {24'd0, seg},  32'hFF);
        checkField("rst2_rdata", rdata,         32'd0);
        checkField("rst2_rsel",  {31'd0, rsel}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            idleRead(OFF_BTN);
            checkField($sformatf("rst2_btn_k%0d", k), rdata, (k >= 7) ? 32'd4 : 32'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            int          b;
            if ($urandom_range(5) == 0) begin
                b = $urandom_range(2);
                buttons_n[b] = ~buttons_n[b];
            end
            if ($urandom_range(15) == 0) switchs = 10'($urandom());
            if ($urandom_range(7) == 0)
                a = $urandom();
            else
                a = {24'hFF_FFFF, 6'($urandom_range(16)), 2'($urandom_range(3))};
            applyStimulus(($urandom_range(299) == 0), a, $urandom(), ($urandom_range(2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
